// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared types, digit limits and BCD validity check for cook_timer
package cook_timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COUNTING,
      DONE
   } state_t;

   localparam int                BCD_W        = 4;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

   // MM:SS packed as {min_tens, min_ones, sec_tens, sec_ones}
   function automatic logic bcd_valid(input logic [4*BCD_W-1:0] t);
      return (t[15:12] <= DIGIT_MAX) && (t[11:8] <= DIGIT_MAX) &&
             (t[7:4] <= SEC_TENS_MAX) && (t[3:0] <= DIGIT_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one down-counting BCD digit with borrow chain
module bcd_digit_down
   import cook_timer_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             dec_en,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit,
   output logic             borrow_out
);

   assign borrow_out = borrow_in && (digit == '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         digit <= '0;
      end else if (clear) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_val;
      end else if (dec_en && borrow_in) begin
         digit <= (digit == '0) ? MAX : digit - 1'b1;
      end
   end

endmodule

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - BCD MM:SS countdown timer driving the magnetron timer_done input
module cook_timer
   import cook_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        clearn,
   input  logic        load,
   input  logic [15:0] time_in,
   input  logic        run,
   output logic [15:0] time_out,
   output logic        timer_done,
   output logic        counting,
   output logic        load_err
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   state_t        state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic          done_next, counting_next, load_err_next;
   logic          load_ok, load_bad, active, tick, dec, last_sec;
   logic [4:0]    borrow;

   assign load_ok  = load && bcd_valid(time_in);
   assign load_bad = load && !bcd_valid(time_in);
   assign active   = (state == ARMED) || (state == COUNTING);
   assign tick     = run && active && (presc == PRESC_LAST);
   assign dec      = clearn && !load && tick;
   assign last_sec = (time_out == 16'h0001);
   assign borrow[0] = 1'b1;

   // borrow[4] would mean 00:00 wrapping to 99:59, so it blocks the decrement
   bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
      .clk(clk), .resetn(resetn), .clear(!clearn), .load(load_ok),
      .load_val(time_in[3:0]), .dec_en(dec && !borrow[4]), .borrow_in(borrow[0]),
      .digit(time_out[3:0]), .borrow_out(borrow[1])
   );
   bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .resetn(resetn), .clear(!clearn), .load(load_ok),
      .load_val(time_in[7:4]), .dec_en(dec && !borrow[4]), .borrow_in(borrow[1]),
      .digit(time_out[7:4]), .borrow_out(borrow[2])
   );
   bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
      .clk(clk), .resetn(resetn), .clear(!clearn), .load(load_ok),
      .load_val(time_in[11:8]), .dec_en(dec && !borrow[4]), .borrow_in(borrow[2]),
      .digit(time_out[11:8]), .borrow_out(borrow[3])
   );
   bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_tens (
      .clk(clk), .resetn(resetn), .clear(!clearn), .load(load_ok),
      .load_val(time_in[15:12]), .dec_en(dec && !borrow[4]), .borrow_in(borrow[3]),
      .digit(time_out[15:12]), .borrow_out(borrow[4])
   );

   always_comb begin
      state_next    = state;
      presc_next    = presc;
      done_next     = timer_done;
      load_err_next = 1'b0;
      if (!clearn) begin
         state_next = IDLE;
         presc_next = '0;
         done_next  = 1'b0;
      end else if (load_ok) begin
         state_next = (time_in == 16'h0000) ? IDLE : ARMED;
         presc_next = '0;
         done_next  = 1'b0;
      end else if (load_bad) begin
         load_err_next = 1'b1;
      end else begin
         if (run && active)
            presc_next = tick ? '0 : presc + 1'b1;
         if (tick && last_sec) begin
            state_next = DONE;
            done_next  = 1'b1;
         end else if (active) begin
            state_next = run ? COUNTING : ARMED;
         end
      end
      counting_next = (state_next == COUNTING);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         presc      <= '0;
         timer_done <= 1'b0;
         counting   <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state      <= state_next;
         presc      <= presc_next;
         timer_done <= done_next;
         counting   <= counting_next;
         load_err   <= load_err_next;
      end
   end

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - directed self-checking bench for cook_timer
module tb_cook_timer;

   logic        clk = 1'b0;
   logic        resetn, clearn, load, run;
   logic [15:0] time_in;
   logic [15:0] time_out;
   logic        timer_done, counting, load_err;

   int total = 0;
   int bad   = 0;

   cook_timer #(.TICKS_PER_SEC(4)) dut (
      .clk(clk), .resetn(resetn), .clearn(clearn), .load(load),
      .time_in(time_in), .run(run), .time_out(time_out),
      .timer_done(timer_done), .counting(counting), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      load    = 1'b1;
      time_in = v;
      step();
      load    = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; clearn = 1'b1; load = 1'b0; run = 1'b0; time_in = 16'h0000;
      step();
      check("rst_time", time_out, 16'h0000);
      check("rst_done", {15'd0, timer_done}, 16'd0);
      check("rst_cnt", {15'd0, counting}, 16'd0);
      check("rst_err", {15'd0, load_err}, 16'd0);
      resetn = 1'b1;

      // idle with run high: nothing moves
      run = 1'b1;
      repeat (8) begin
         step();
         check("idle_time", time_out, 16'h0000);
         check("idle_flags", {13'd0, timer_done, counting, load_err}, 16'd0);
      end

      // 00:03 countdown to done
      run = 1'b0;
      do_load(16'h0003);
      check("ld3_time", time_out, 16'h0003);
      run = 1'b1;
      repeat (3) step();
      check("cd_pre", time_out, 16'h0003);
      step();
      check("cd_4", time_out, 16'h0002);
      check("cd_cnt", {15'd0, counting}, 16'd1);
      repeat (4) step();
      check("cd_8", time_out, 16'h0001);
      check("cd_8_done", {15'd0, timer_done}, 16'd0);
      repeat (4) step();
      check("cd_12", time_out, 16'h0000);
      check("cd_12_done", {15'd0, timer_done}, 16'd1);
      repeat (20) step();
      check("done_hold_t", time_out, 16'h0000);
      check("done_hold", {15'd0, timer_done}, 16'd1);
      check("done_cnt", {15'd0, counting}, 16'd0);
      run = 1'b0;
      do_load(16'h0005);
      check("reld_time", time_out, 16'h0005);
      check("reld_done", {15'd0, timer_done}, 16'd0);
      check("reld_err", {15'd0, load_err}, 16'd0);

      // borrow chain
      do_load(16'h0100);
      run = 1'b1;
      repeat (4) step();
      check("borrow_0100", time_out, 16'h0059);
      run = 1'b0;
      do_load(16'h1000);
      run = 1'b1;
      repeat (4) step();
      check("borrow_1000", time_out, 16'h0959);

      // pause keeps the fraction of a second
      run = 1'b0;
      do_load(16'h0002);
      run = 1'b1;
      repeat (2) step();
      run = 1'b0;
      repeat (10) step();
      check("pause_time", time_out, 16'h0002);
      check("pause_cnt", {15'd0, counting}, 16'd0);
      run = 1'b1;
      step();
      check("resume_1", time_out, 16'h0002);
      step();
      check("resume_2", time_out, 16'h0001);

      // invalid loads rejected
      run = 1'b0;
      do_load(16'h0030);
      do_load(16'h0075);
      check("inv75_err", {15'd0, load_err}, 16'd1);
      check("inv75_time", time_out, 16'h0030);
      step();
      check("inv75_err1", {15'd0, load_err}, 16'd0);
      do_load(16'h0A00);
      check("inv0A_err", {15'd0, load_err}, 16'd1);
      check("inv0A_time", time_out, 16'h0030);
      step();
      check("inv0A_err1", {15'd0, load_err}, 16'd0);
      check("inv0A_time1", time_out, 16'h0030);

      // zero load stays idle and never wraps
      do_load(16'h0000);
      run = 1'b1;
      repeat (8) step();
      check("zero_time", time_out, 16'h0000);
      check("zero_done", {15'd0, timer_done}, 16'd0);

      // clear beats load while done
      run = 1'b0;
      do_load(16'h0001);
      run = 1'b1;
      repeat (4) step();
      check("d1_done", {15'd0, timer_done}, 16'd1);
      clearn = 1'b0; load = 1'b1; time_in = 16'h0045;
      step();
      clearn = 1'b1; load = 1'b0;
      check("clr_time", time_out, 16'h0000);
      check("clr_flags", {13'd0, timer_done, counting, load_err}, 16'd0);
      repeat (8) step();
      check("clr_idle", time_out, 16'h0000);
      check("clr_idle_dn", {15'd0, timer_done}, 16'd0);

      // reset mid-count
      run = 1'b0;
      do_load(16'h0012);
      run = 1'b1;
      repeat (5) step();
      check("mid_time", time_out, 16'h0011);
      resetn = 1'b0;
      step();
      check("mid_rst_t", time_out, 16'h0000);
      check("mid_rst_f", {13'd0, timer_done, counting, load_err}, 16'd0);
      resetn = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
Countdown cook timer for the microwave controller. It holds the cook time as BCD MM:SS and counts down one second at a time while the magnetron is energised. It drives timer_done, which is the timer_done input of the magnetron control latch. It also drives the display value.

Parameters:
TICKS_PER_SEC, 100, clk cycles per one-second decrement; 4 in simulation, must be >=2.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
clearn  input  1  synchronous active-low clear (keypad CLEAR); zeroes time, drops done
load  input  1  one-cycle pulse; capture time_in
time_in  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
run  input  1  count enable; driven by magnetron Q
time_out  output  16  current BCD MM:SS remaining
timer_done  output  1  level; high once count reaches 00:00 from a nonzero load
counting  output  1  high in COUNTING state while run=1
load_err  output  1  one-cycle pulse on rejected load

Behaviour:
- Reset (resetn=0 at edge): time_out=16'h0000, timer_done=0, counting=0, load_err=0, prescaler=0, state=IDLE.
- Priority at each edge: resetn > clearn > load > tick.
- States:
  - IDLE: time is 00:00 and done=0.
  - ARMED: time is nonzero and the prescaler is paused because run=0.
  - COUNTING: run=1 and time is nonzero.
  - DONE: time is 00:00 and done=1.
- clearn=0: time=0000, prescaler=0, done=0, state goes to IDLE. This happens from any state and overrides a simultaneous load.
- load with valid BCD:
  - Valid means every digit <=9 and sec_tens <=5.
  - time is set to time_in and prescaler to 0. done and load_err are 0.
  - Next state is IDLE if time_in==0000, otherwise ARMED.
  - A load accepted while COUNTING or DONE restarts from the new value.
- load with invalid BCD: time, state and prescaler are unchanged, and load_err=1 for exactly one cycle.
- Prescaler:
  - It advances only when run=1 and state is ARMED or COUNTING.
  - It holds its value when run=0, so a pause keeps the fraction of the current second.
  - tick = run && prescaler==TICKS_PER_SEC-1. On tick the prescaler wraps to 0 and time decrements by one second.
  - With run held high from the cycle after load, the first decrement is visible TICKS_PER_SEC cycles after load.
- BCD decrement, borrow chain sec_ones -> sec_tens -> min_ones -> min_tens:
  - sec_ones 0 becomes 9 and borrows.
  - sec_tens 0 becomes 5 and borrows.
  - min_ones 0 becomes 9 and borrows.
  - min_tens decrements.
  - Examples: 01:00 becomes 00:59, and 10:00 becomes 09:59.
- Terminal count: a tick with time==00:01 gives time=00:00 and timer_done=1 registered on the same edge; state goes to DONE.
- timer_done holds until clearn, a valid load, or reset.
- In IDLE and DONE, run is ignored and the prescaler stays at 0; 00:00 never wraps to 99:59.
- counting = (state==COUNTING) && run, registered.
- load_err is never asserted by a valid load or by clearn.

Decomposition:
- Shared package cook_timer_pkg holds:
  - state typedef {IDLE, ARMED, COUNTING, DONE};
  - BCD_W=4;
  - SEC_TENS_MAX=5 and DIGIT_MAX=9;
  - the bcd_valid() function.
- Sub-module bcd_digit_down (parameter MAX): one BCD digit with load, dec_en, borrow_in and borrow_out. It is instantiated four times; MAX=5 for sec_tens and MAX=9 for the other digits.
- The prescaler and FSM live in the top level.

Test Plan (TICKS_PER_SEC=4):
- Reset, then idle with run=1 -> time_out=0000, timer_done=0, counting=0 throughout.
- load 0003, then run=1 continuously -> time_out is 0002 at load+4, 0001 at +8, 0000 with timer_done=1 at +12. Done stays high 20 more cycles, and clears on load 0005.
- Borrow: load 0100, run 4 cycles -> 0059; load 1000, run 4 cycles -> 0959.
- Pause: load 0002, run=1 for 2 cycles, run=0 for 10 cycles -> time stays 0002 and counting=0. Then run=1 -> 0001 after exactly 2 more cycles.
- Invalid load: load 0075 while time=0030 -> load_err high for one cycle, time_out stays 0030. Load 0A00 -> same behaviour.
- Simultaneous clearn=0 and load 0045 in DONE -> time_out=0000, timer_done=0, state IDLE, load_err=0. Reset asserted mid-count (time 0012) -> all outputs at reset values on the next edge.
